link_align_ctrl: RTL and testbench
==================================

LINK_ALIGN_CTRL -- requirements
Module: link_align_ctrl

Interface
REQ-001 SHALL have parameter g_IDLE, default 16'hbc95, IDLE word.
REQ-002 SHALL have parameter g_IDLE_K, default 2'b10, charisk of IDLE.
REQ-003 SHALL have parameter g_IDLE_PERIOD, default 193, TX IDLE insertion period (cycles).
REQ-004 SHALL have parameter g_BLIND_PERIOD, default 10, post-alignment ignore cycles.
REQ-005 SHALL have parameter g_LOCK_IDLES, default 8, consecutive good IDLEs to declare link up.
REQ-006 SHALL have parameter g_ALIGN_TIMEOUT, default 4096, max cycles awaiting rx_aligned_i.
REQ-007 SHALL have one clock and an asynchronous, active-high reset, with ports: usrclk_i  in  1  clock; rst_i  in  1  reset.
REQ-008 gt_ready_i  in  1  GT reset done / link valid.
REQ-009 rx_data_i  in  16  GT RX data; rx_k_i  in  2  RX charisk.
REQ-010 rx_aligned_i  in  1  GT byte alignment achieved; rx_bufstatus_i  in  3  elastic buffer status.
REQ-011 rx_realign_o  out  1  request comma realignment.
REQ-012 tx_data_i  in  16  user TX word; tx_k_i  in  2  user charisk; tx_ready_o  out  1  user word accepted this cycle.
REQ-013 tx_data_o  out  16, tx_k_o  out  2  to GT TX.
REQ-014 link_up_o  out  1; state_o  out  3  FSM encoding; resync_cnt_o  out  8  realignment count.

Function
REQ-015 FSM states: WAIT_GT=0, REALIGN=1, WAIT_ALIGN=2, BLIND=3, HUNT=4, UP=5; state_o = current state, registered.
REQ-016 gt_ready_i=0 in any state -> WAIT_GT next cycle; no resync count; overrides all other transitions.
REQ-017 WAIT_GT: gt_ready_i=1 -> REALIGN.
REQ-018 REALIGN: lasts exactly 1 cycle, rx_realign_o=0 (deassert pulse), -> WAIT_ALIGN.
REQ-019 WAIT_ALIGN: rx_realign_o=1; rx_aligned_i=1 -> BLIND; g_ALIGN_TIMEOUT cycles elapsed without alignment -> REALIGN.
REQ-020 BLIND: rx data ignored for exactly g_BLIND_PERIOD cycles, then -> HUNT; rx_aligned_i=0 -> REALIGN.
REQ-021 HUNT: word with rx_k_i==g_IDLE_K and rx_data_i==g_IDLE increments good-IDLE counter; rx_k_i==00 neutral (counter held); any other K pattern or K word mismatch -> REALIGN.
REQ-022 HUNT: counter reaching g_LOCK_IDLES -> UP; no good IDLE within 2*g_IDLE_PERIOD cycles -> REALIGN.
REQ-023 UP: link_up_o=1 (registered, asserted first cycle in UP); exit to REALIGN on rx_aligned_i=0, bad K as REQ-021, or rx_bufstatus_i[2]=1.
REQ-024 Every transition into REALIGN from WAIT_ALIGN, BLIND, HUNT or UP increments resync_cnt_o, saturating at 255.
REQ-025 Simultaneous error sources same cycle: single REALIGN, single increment.
REQ-026 All per-state counters clear on state entry.
REQ-027 TX scheduler: free-running counter 0..g_IDLE_PERIOD-1, wraps to 0.
REQ-028 tx_ready_o (combinational) = link_up_o AND counter!=0.
REQ-029 Next cycle: tx_data_o/tx_k_o = tx_data_i/tx_k_i when tx_ready_o=1, else g_IDLE/g_IDLE_K; 1-cycle latency.

Reset
REQ-030 rst_i=1 asynchronously forces: state WAIT_GT, rx_realign_o=0, link_up_o=0, resync_cnt_o=0, tx_data_o=g_IDLE, tx_k_o=g_IDLE_K, all counters 0.
REQ-031 Reset asserted mid-operation (incl. UP) SHALL take effect without waiting for a clock edge; resync_cnt_o is cleared.

Structure
REQ-032 State encoding constants and IDLE/K defaults SHALL reside in shared package link_ctrl_pkg.
REQ-033 TX IDLE scheduler (REQ-027..029) SHALL be sub-module tx_idle_inserter.

Verification
REQ-034 gt_ready_i=1, rx_aligned_i=1 after 20 cycles, clean IDLE/data stream -> states 0,1,2,3,4,5; link_up_o=1 after 8 good IDLEs; resync_cnt_o=0.
REQ-035 rx_aligned_i held 0 -> REALIGN every 4097 cycles; resync_cnt_o increments per timeout, saturates at 255.
REQ-036 In UP inject rx_k_i=01 with data 16'h95bc -> link_up_o=0 next cycle, state REALIGN, resync_cnt_o+1.
REQ-037 In UP rx_bufstatus_i=3'b101 together with rx_aligned_i=0 -> one REALIGN, resync_cnt_o+1 only.
REQ-038 link up, tx_data_i=16'h1234 constant -> tx_data_o=16'hbc95/K=10 exactly once per 193 cycles, else 16'h1234/K=00; tx_ready_o=0 on IDLE slots.
REQ-039 rst_i pulsed mid-UP between clock edges -> outputs at reset values immediately; gt_ready_i drop in HUNT -> WAIT_GT, count unchanged.

Source files
------------

// File: rtl/link_ctrl_pkg.sv
// Shared link-control types and constants.
// State encoding and default IDLE ordered set.
package link_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_GT    = 3'd0,
        ST_REALIGN    = 3'd1,
        ST_WAIT_ALIGN = 3'd2,
        ST_BLIND      = 3'd3,
        ST_HUNT       = 3'd4,
        ST_UP         = 3'd5
    } link_state_t;

    localparam logic [15:0] IDLE_WORD    = 16'hbc95;
    localparam logic [1:0]  IDLE_CHARISK = 2'b10;
    localparam logic [7:0]  RESYNC_MAX   = 8'hff;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tx_idle_inserter.sv
// TX IDLE scheduler: one IDLE slot per period,
// user words forwarded in all other slots.
module tx_idle_inserter
    import link_ctrl_pkg::*;
#(
    parameter logic [15:0] g_IDLE        = IDLE_WORD,
    parameter logic [1:0]  g_IDLE_K      = IDLE_CHARISK,
    parameter int          g_IDLE_PERIOD = 193
) (
    input  logic        usrclk_i,
    input  logic        rst_i,
    input  logic        link_up_i,
    input  logic [15:0] tx_data_i,
    input  logic [1:0]  tx_k_i,
    output logic        tx_ready_o,
    output logic [15:0] tx_data_o,
    output logic [1:0]  tx_k_o
);

    localparam int CW = (g_IDLE_PERIOD > 1) ? $clog2(g_IDLE_PERIOD) : 1;

    logic [CW-1:0] slot_cnt;

    // Free-running slot counter, slot 0 is the IDLE slot.
    always_ff @(posedge usrclk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_cnt <= '0;
        end else if (slot_cnt == CW'(g_IDLE_PERIOD - 1)) begin
            slot_cnt <= '0;
        end else begin
            slot_cnt <= slot_cnt + CW'(1);
        end
    end

    assign tx_ready_o = link_up_i && (slot_cnt != '0);

    // Register the word sent to the GT: user word or IDLE.
    always_ff @(posedge usrclk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_data_o <= g_IDLE;
            tx_k_o    <= g_IDLE_K;
        end else if (tx_ready_o) begin
            tx_data_o <= tx_data_i;
            tx_k_o    <= tx_k_i;
        end else begin
            tx_data_o <= g_IDLE;
            tx_k_o    <= g_IDLE_K;
        end
    end

endmodule

// File: rtl/link_align_ctrl.sv
// Link alignment controller: comma realign, IDLE hunt,
// link-up monitoring and TX IDLE insertion.
module link_align_ctrl
    import link_ctrl_pkg::*;
#(
    parameter logic [15:0] g_IDLE          = IDLE_WORD,
    parameter logic [1:0]  g_IDLE_K        = IDLE_CHARISK,
    parameter int          g_IDLE_PERIOD   = 193,
    parameter int          g_BLIND_PERIOD  = 10,
    parameter int          g_LOCK_IDLES    = 8,
    parameter int          g_ALIGN_TIMEOUT = 4096
) (
    input  logic        usrclk_i,
    input  logic        rst_i,
    input  logic        gt_ready_i,
    input  logic [15:0] rx_data_i,
    input  logic [1:0]  rx_k_i,
    input  logic        rx_aligned_i,
    input  logic [2:0]  rx_bufstatus_i,
    output logic        rx_realign_o,
    input  logic [15:0] tx_data_i,
    input  logic [1:0]  tx_k_i,
    output logic        tx_ready_o,
    output logic [15:0] tx_data_o,
    output logic [1:0]  tx_k_o,
    output logic        link_up_o,
    output logic [2:0]  state_o,
    output logic [7:0]  resync_cnt_o
);

    localparam int MAXC = max2(max2(g_ALIGN_TIMEOUT, 2 * g_IDLE_PERIOD),
                               max2(g_BLIND_PERIOD, g_LOCK_IDLES));
    localparam int CW   = $clog2(MAXC + 1);

    link_state_t   state, state_n;
    logic [CW-1:0] state_cnt, state_cnt_n;
    logic [CW-1:0] idle_cnt, idle_cnt_n;
    logic          resync_inc;
    logic          good_idle, neutral_k, bad_k;

    assign good_idle = (rx_k_i == g_IDLE_K) && (rx_data_i == g_IDLE);
    assign neutral_k = (rx_k_i == 2'b00);
    assign bad_k     = !good_idle && !neutral_k;

    // State register, per-state counters and registered flags.
    always_ff @(posedge usrclk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= ST_WAIT_GT;
            state_cnt    <= '0;
            idle_cnt     <= '0;
            rx_realign_o <= 1'b0;
            link_up_o    <= 1'b0;
            resync_cnt_o <= '0;
        end else begin
            state        <= state_n;
            state_cnt    <= state_cnt_n;
            idle_cnt     <= idle_cnt_n;
            rx_realign_o <= (state_n == ST_WAIT_ALIGN);
            link_up_o    <= (state_n == ST_UP);
            if (resync_inc && resync_cnt_o != RESYNC_MAX) begin
                resync_cnt_o <= resync_cnt_o + 8'd1;
            end
        end
    end

    // Next-state logic; one REALIGN per cycle however many faults.
    always_comb begin
        state_n     = state;
        state_cnt_n = state_cnt + CW'(1);
        idle_cnt_n  = idle_cnt;
        resync_inc  = 1'b0;
        unique case (state)
            ST_WAIT_GT: begin
                state_cnt_n = '0;
                if (gt_ready_i) state_n = ST_REALIGN;
            end
            ST_REALIGN: begin
                state_n = ST_WAIT_ALIGN;
            end
            ST_WAIT_ALIGN: begin
                if (rx_aligned_i) begin
                    state_n = ST_BLIND;
                end else if (state_cnt == CW'(g_ALIGN_TIMEOUT - 1)) begin
                    state_n = ST_REALIGN;
                end
            end
            ST_BLIND: begin
                if (!rx_aligned_i) begin
                    state_n = ST_REALIGN;
                end else if (state_cnt == CW'(g_BLIND_PERIOD - 1)) begin
                    state_n = ST_HUNT;
                end
            end
            ST_HUNT: begin
                if (bad_k) begin
                    state_n = ST_REALIGN;
                end else if (good_idle) begin
                    state_cnt_n = '0;
                    idle_cnt_n  = idle_cnt + CW'(1);
                    if (idle_cnt == CW'(g_LOCK_IDLES - 1)) state_n = ST_UP;
                end else if (state_cnt == CW'(2 * g_IDLE_PERIOD - 1)) begin
                    state_n = ST_REALIGN;
                end
            end
            ST_UP: begin
                state_cnt_n = '0;
                if (!rx_aligned_i || bad_k || rx_bufstatus_i[2]) begin
                    state_n = ST_REALIGN;
                end
            end
            default: begin
                state_n = ST_WAIT_GT;
            end
        endcase
        if (!gt_ready_i) state_n = ST_WAIT_GT;
        if (state_n != state) begin
            state_cnt_n = '0;
            idle_cnt_n  = '0;
        end
        resync_inc = (state_n == ST_REALIGN) &&
                     (state == ST_WAIT_ALIGN || state == ST_BLIND ||
                      state == ST_HUNT || state == ST_UP);
    end

    assign state_o = state;

    tx_idle_inserter #(
        .g_IDLE        (g_IDLE),
        .g_IDLE_K      (g_IDLE_K),
        .g_IDLE_PERIOD (g_IDLE_PERIOD)
    ) u_tx_idle (
        .usrclk_i   (usrclk_i),
        .rst_i      (rst_i),
        .link_up_i  (link_up_o),
        .tx_data_i  (tx_data_i),
        .tx_k_i     (tx_k_i),
        .tx_ready_o (tx_ready_o),
        .tx_data_o  (tx_data_o),
        .tx_k_o     (tx_k_o)
    );

endmodule

// File: tb/tb_link_align_ctrl.sv
// Directed bench for link_align_ctrl.
// Align timeout shortened to 32 so saturation fits the run.
module tb_link_align_ctrl;

    localparam int TMO = 32;
    localparam int PER = 193;

    logic        clk = 1'b0;
    logic        rst;
    logic        gt_ready;
    logic [15:0] rx_data;
    logic [1:0]  rx_k;
    logic        rx_aligned;
    logic [2:0]  rx_bufstatus;
    logic        rx_realign;
    logic [15:0] tx_data_in;
    logic [1:0]  tx_k_in;
    logic        tx_ready;
    logic [15:0] tx_data_out;
    logic [1:0]  tx_k_out;
    logic        link_up;
    logic [2:0]  state;
    logic [7:0]  resync_cnt;

    int n_vec = 0;
    int n_err = 0;
    int mdl_slot;

    link_align_ctrl #(
        .g_IDLE_PERIOD   (PER),
        .g_ALIGN_TIMEOUT (TMO)
    ) dut (
        .usrclk_i       (clk),
        .rst_i          (rst),
        .gt_ready_i     (gt_ready),
        .rx_data_i      (rx_data),
        .rx_k_i         (rx_k),
        .rx_aligned_i   (rx_aligned),
        .rx_bufstatus_i (rx_bufstatus),
        .rx_realign_o   (rx_realign),
        .tx_data_i      (tx_data_in),
        .tx_k_i         (tx_k_in),
        .tx_ready_o     (tx_ready),
        .tx_data_o      (tx_data_out),
        .tx_k_o         (tx_k_out),
        .link_up_o      (link_up),
        .state_o        (state),
        .resync_cnt_o   (resync_cnt)
    );

    always #5 clk = ~clk;

    // Reference TX slot counter.
    always @(posedge clk or posedge rst) begin
        if (rst) mdl_slot <= 0;
        else     mdl_slot <= (mdl_slot == PER - 1) ? 0 : mdl_slot + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rx_idle();
        rx_data = 16'hbc95;
        rx_k    = 2'b10;
    endtask

    // From REALIGN with a clean aligned stream to UP.
    task automatic bring_up(input string tag);
        tick(1);
        chk({tag, "_wa"}, 32'(state), 2);
        tick(1);
        chk({tag, "_blind"}, 32'(state), 3);
        tick(10);
        chk({tag, "_hunt"}, 32'(state), 4);
        tick(8);
        chk({tag, "_up"}, 32'(state), 5);
        chk({tag, "_lnk"}, 32'(link_up), 1);
    endtask

    int idles;
    int last_idle;
    bit exp_rdy;

    initial begin
        rst          = 1'b0;
        gt_ready     = 1'b0;
        rx_aligned   = 1'b0;
        rx_bufstatus = 3'b000;
        tx_data_in   = 16'h1234;
        tx_k_in      = 2'b00;
        rx_idle();
        #1 rst = 1'b1;
        tick(3);
        chk("rst_state", 32'(state), 0);
        chk("rst_lnk", 32'(link_up), 0);
        chk("rst_realign", 32'(rx_realign), 0);
        chk("rst_resync", 32'(resync_cnt), 0);
        chk("rst_txd", 32'(tx_data_out), 'hbc95);
        chk("rst_txk", 32'(tx_k_out), 'b10);
        chk("rst_rdy", 32'(tx_ready), 0);

        // Normal bring-up.
        gt_ready = 1'b1;
        rst      = 1'b0;
        tick(1);
        chk("up_realign", 32'(state), 1);
        chk("up_realign_o0", 32'(rx_realign), 0);
        tick(1);
        chk("up_wa", 32'(state), 2);
        chk("up_realign_o1", 32'(rx_realign), 1);
        tick(17);
        chk("up_wa_hold", 32'(state), 2);
        rx_aligned = 1'b1;
        tick(1);
        chk("up_blind", 32'(state), 3);
        tick(9);
        chk("up_blind_end", 32'(state), 3);
        tick(1);
        chk("up_hunt", 32'(state), 4);
        tick(3);
        rx_data = 16'h1234;
        rx_k    = 2'b00;
        tick(1);
        rx_idle();
        tick(4);
        chk("up_hunt7", 32'(state), 4);
        chk("up_lnk0", 32'(link_up), 0);
        tick(1);
        chk("up_state", 32'(state), 5);
        chk("up_lnk", 32'(link_up), 1);
        chk("up_resync", 32'(resync_cnt), 0);

        // TX IDLE insertion over two periods.
        idles     = 0;
        last_idle = -1;
        for (int i = 0; i < 2 * PER; i++) begin
            exp_rdy = (mdl_slot != 0);
            chk("tx_rdy", 32'(tx_ready), 32'(exp_rdy));
            tick(1);
            if (exp_rdy) begin
                chk("tx_data", 32'(tx_data_out), 'h1234);
                chk("tx_k", 32'(tx_k_out), 0);
            end else begin
                chk("tx_idle", 32'(tx_data_out), 'hbc95);
                chk("tx_idle_k", 32'(tx_k_out), 'b10);
                if (last_idle >= 0) chk("tx_gap", i - last_idle, PER);
                last_idle = i;
                idles++;
            end
        end
        chk("tx_idles", idles, 2);

        // Bad K in UP.
        rx_data = 16'h95bc;
        rx_k    = 2'b01;
        tick(1);
        rx_idle();
        chk("badk_state", 32'(state), 1);
        chk("badk_lnk", 32'(link_up), 0);
        chk("badk_resync", 32'(resync_cnt), 1);
        bring_up("badk");

        // Two simultaneous faults, one resync.
        rx_bufstatus = 3'b101;
        rx_aligned   = 1'b0;
        tick(1);
        rx_bufstatus = 3'b000;
        rx_aligned   = 1'b1;
        chk("dual_state", 32'(state), 1);
        chk("dual_resync", 32'(resync_cnt), 2);

        // gt_ready drop in HUNT.
        tick(2);
        tick(10);
        chk("gt_hunt", 32'(state), 4);
        gt_ready = 1'b0;
        tick(1);
        chk("gt_waitgt", 32'(state), 0);
        chk("gt_resync", 32'(resync_cnt), 2);
        gt_ready = 1'b1;
        tick(1);
        chk("gt_realign", 32'(state), 1);
        chk("gt_resync2", 32'(resync_cnt), 2);
        bring_up("gt");

        // Asynchronous reset between edges.
        #2 rst = 1'b1;
        #1;
        chk("arst_state", 32'(state), 0);
        chk("arst_lnk", 32'(link_up), 0);
        chk("arst_resync", 32'(resync_cnt), 0);
        chk("arst_txd", 32'(tx_data_out), 'hbc95);
        chk("arst_txk", 32'(tx_k_out), 'b10);
        chk("arst_realign", 32'(rx_realign), 0);

        // Alignment timeout and saturation.
        rx_aligned = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(1);
        chk("tmo_realign", 32'(state), 1);
        tick(1);
        chk("tmo_wa", 32'(state), 2);
        tick(TMO - 1);
        chk("tmo_wa_end", 32'(state), 2);
        chk("tmo_resync0", 32'(resync_cnt), 0);
        tick(1);
        chk("tmo_first", 32'(state), 1);
        chk("tmo_resync1", 32'(resync_cnt), 1);
        for (int k = 2; k <= 258; k++) begin
            tick(TMO + 1);
            chk("tmo_state", 32'(state), 1);
            chk("tmo_resync", 32'(resync_cnt), (k > 255) ? 255 : k);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
